// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu datapath.
//   ALU_OP_W       - width of the ALU opcode field
//   ALU_ADD..SLT   - ALU opcode encodings (3'b000..3'b111)
//   state_e        - alu_arbiter sequencing states (S_IDLE/S_EXEC/S_RESP)
package cpu_pkg;

    localparam int unsigned ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_grant2.sv
// rr_grant2: combinational 2-way round-robin picker.
//   valid_i[1:0]  - request lines
//   last_i        - id of the most recently granted requester
//   grant_vld_o   - some requester is granted
//   grant_id_o    - id of the granted requester (meaningful when grant_vld_o)
module rr_grant2
    import cpu_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic       grant_vld_o,
    output logic       grant_id_o
);

    always_comb begin
        grant_vld_o = |valid_i;
        grant_id_o  = 1'b0;
        unique case (valid_i)
            2'b01:   grant_id_o = 1'b0;
            2'b10:   grant_id_o = 1'b1;
            2'b11:   grant_id_o = ~last_i;   // contended: favour the one not served last
            default: grant_id_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Each operation runs accept (IDLE) -> execute (EXEC, 1 cycle) -> respond (RESP).
//   clk, rst_n                    - clock (rising edge), async active-low reset
//   req_valid/req_ready[1:0]      - request handshake, bit i = requester i
//   req_a0/b0/op0, req_a1/b1/op1  - per-requester operands and opcode
//   rsp_valid/rsp_ready[1:0]      - response handshake, bit i = requester i
//   rsp_data                      - shared result, qualified by rsp_valid
//   alu_a, alu_b, alu_control     - registered ALU inputs
//   alu_result                    - ALU output
//   busy                          - high whenever not IDLE
//   done_cnt0/done_cnt1           - saturating completed-operation counters
module alu_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [WIDTH-1:0]    req_a0,
    input  logic [WIDTH-1:0]    req_b0,
    input  logic [ALU_OP_W-1:0] req_op0,
    input  logic [WIDTH-1:0]    req_a1,
    input  logic [WIDTH-1:0]    req_b1,
    input  logic [ALU_OP_W-1:0] req_op1,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [ALU_OP_W-1:0] alu_control,
    input  logic [WIDTH-1:0]    alu_result,
    output logic                busy,
    output logic [CNT_W-1:0]    done_cnt0,
    output logic [CNT_W-1:0]    done_cnt1
);

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic [WIDTH-1:0]      alu_a_q, alu_a_d;
    logic [WIDTH-1:0]      alu_b_q, alu_b_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]      cnt0_q, cnt0_d;
    logic [CNT_W-1:0]      cnt1_q, cnt1_d;

    logic                  grant_vld;
    logic                  grant_id;

    rr_grant2 u_rr_grant2 (
        .valid_i     (req_valid),
        .last_i      (last_q),
        .grant_vld_o (grant_vld),
        .grant_id_o  (grant_id)
    );

    // req_ready is combinational from req_valid; gating with rst_n keeps it
    // low while reset is held even if a requester is already asserting valid.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (state_q == S_IDLE) && grant_vld) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        unique case (state_q)
            S_IDLE: begin
                // A grant implies the granted requester is valid, so the
                // handshake completes at this edge.
                if (grant_vld) begin
                    owner_d  = grant_id;
                    last_d   = grant_id;
                    alu_a_d  = grant_id ? req_a1  : req_a0;
                    alu_b_d  = grant_id ? req_b1  : req_b0;
                    alu_op_d = grant_id ? req_op1 : req_op0;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d  = alu_result;
                rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    if (owner_q) begin
                        if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_op_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign done_cnt0   = cnt0_q;
    assign done_cnt1   = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small ALU model
// standing in for the shared alu instance.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [WIDTH-1:0]  req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [2:0]        req_op0 = '0, req_op1 = '0;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready = 2'b00;
    logic [WIDTH-1:0]  rsp_data, alu_a, alu_b, alu_result;
    logic [2:0]        alu_control;
    logic              busy;
    logic [CNT_W-1:0]  done_cnt0, done_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .busy(busy),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    // Reference ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT
    always_comb begin
        alu_result = '0;
        case (alu_control)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = alu_a << alu_b;
            3'b110: alu_result = alu_a >> alu_b;
            default: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_control, done_cnt0, done_cnt1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b rdy=%b rv=%b data=%h a=%h b=%h op=%h c0=%0d c1=%0d",
                     busy, req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_control, done_cnt0, done_cnt1);
        end
    endtask

    task automatic test_single();
        req_a0 = 32'd5; req_b0 = 32'd3; req_op0 = 3'b001;
        req_valid = 2'b01; rsp_ready = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
        step();
        req_valid = 2'b00;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00 || alu_a !== 32'd5 || alu_b !== 32'd3 || alu_control !== 3'b001) begin
            errors++;
            $display("FAIL single_exec busy=%b rv=%b a=%h b=%h op=%b exp 1 00 5 3 001", busy, rsp_valid, alu_a, alu_b, alu_control);
        end
        step();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd2) begin
            errors++; $display("FAIL single_rsp rv=%b data=%h exp 01 2", rsp_valid, rsp_data);
        end
        step();
        checks++;
        if (rsp_valid !== 2'b00 || done_cnt0 !== 2'd1 || busy !== 1'b0 || rsp_data !== 32'd2) begin
            errors++; $display("FAIL single_done rv=%b c0=%0d busy=%b data=%h exp 00 1 0 2", rsp_valid, done_cnt0, busy, rsp_data);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_rdy;
        logic [31:0] exp_data;
        do_reset();
        req_a0 = 32'd1;    req_b0 = 32'd1;    req_op0 = 3'b000;
        req_a1 = 32'hF0;   req_b1 = 32'h0F;   req_op1 = 3'b100;
        req_valid = 2'b11; rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_rdy  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_data = (i % 2 == 0) ? 32'd2 : 32'hFF;
            checks++;
            if (req_ready !== exp_rdy) begin errors++; $display("FAIL contend_grant%0d got %b exp %b", i, req_ready, exp_rdy); end
            step();
            checks++;
            if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
                errors++; $display("FAIL contend_exec%0d rv=%b rdy=%b exp 00 00", i, rsp_valid, req_ready);
            end
            step();
            checks++;
            if (rsp_valid !== exp_rdy || rsp_data !== exp_data) begin
                errors++; $display("FAIL contend_rsp%0d rv=%b data=%h exp %b %h", i, rsp_valid, rsp_data, exp_rdy, exp_data);
            end
            step();
            checks++;
            if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
                errors++; $display("FAIL contend_done%0d rv=%b busy=%b exp 00 0", i, rsp_valid, busy);
            end
        end
        checks++;
        if (done_cnt0 !== 2'd2 || done_cnt1 !== 2'd2) begin
            errors++; $display("FAIL contend_counts c0=%0d c1=%0d exp 2 2", done_cnt0, done_cnt1);
        end
    endtask

    task automatic test_backpressure();
        req_a1 = 32'd3; req_b1 = 32'd7; req_op1 = 3'b111;
        req_valid = 2'b10; rsp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_ready got %b exp 10", req_ready); end
        step();
        // requester 0 arrives while the arbiter is busy and must wait
        req_a0 = 32'd9; req_b0 = 32'd4; req_op0 = 3'b001;
        req_valid = 2'b01;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid !== 2'b10 || rsp_data !== 32'd1 || req_ready !== 2'b00 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall%0d rv=%b data=%h rdy=%b busy=%b exp 10 1 00 1", i, rsp_valid, rsp_data, req_ready, busy);
            end
            step();
        end
        checks++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'd1 || done_cnt1 !== 2'd2) begin
            errors++; $display("FAIL bp_hold rv=%b data=%h c1=%0d exp 10 1 2", rsp_valid, rsp_data, done_cnt1);
        end
        rsp_ready = 2'b10;
        step();
        checks++;
        if (rsp_valid !== 2'b00 || done_cnt1 !== 2'd3 || busy !== 1'b0 || req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_done rv=%b c1=%0d busy=%b rdy=%b exp 00 3 0 01", rsp_valid, done_cnt1, busy, req_ready);
        end
    endtask

    task automatic test_wrong_owner();
        // requester 0 already valid with 9-4; rsp_ready still 10
        step();
        req_valid = 2'b00;
        step();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd5) begin
            errors++; $display("FAIL wo_rsp rv=%b data=%h exp 01 5", rsp_valid, rsp_data);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (rsp_valid !== 2'b01 || done_cnt0 !== 2'd2 || busy !== 1'b1) begin
                errors++; $display("FAIL wo_ignore%0d rv=%b c0=%0d busy=%b exp 01 2 1", i, rsp_valid, done_cnt0, busy);
            end
        end
        rsp_ready = 2'b01;
        step();
        checks++;
        if (rsp_valid !== 2'b00 || done_cnt0 !== 2'd3 || done_cnt1 !== 2'd3) begin
            errors++; $display("FAIL wo_done rv=%b c0=%0d c1=%0d exp 00 3 3", rsp_valid, done_cnt0, done_cnt1);
        end
    endtask

    task automatic test_async_reset();
        req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = 3'b000;
        req_valid = 2'b01; rsp_ready = 2'b11;
        step();
        checks++;
        if (busy !== 1'b1 || alu_a !== 32'd1) begin
            errors++; $display("FAIL ar_accept busy=%b a=%h exp 1 1", busy, alu_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_control, done_cnt0, done_cnt1} !== '0) begin
            errors++;
            $display("FAIL ar_immediate busy=%b rdy=%b rv=%b data=%h a=%h b=%h op=%h c0=%0d c1=%0d",
                     busy, req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_control, done_cnt0, done_cnt1);
        end
        step();
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL ar_no_rsp rv=%b busy=%b exp 00 0", rsp_valid, busy);
        end
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL ar_first_grant got %b exp 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        do_reset();
        req_a0 = 32'd4; req_b0 = 32'd4; req_op0 = 3'b000;
        rsp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            req_valid = 2'b01;
            step();
            req_valid = 2'b00;
            step();
            step();
            checks++;
            if (done_cnt0 !== exp_cnt || rsp_data !== 32'd8) begin
                errors++; $display("FAIL sat_op%0d c0=%0d data=%h exp %0d 8", i, done_cnt0, rsp_data, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrong_owner();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
